// File: rtl/cpu_nic.sv
// CPU-side network interface: one-entry input and output packet buffers with a register port.
// Optional 16-bit saturating packet counters are built when NIC_PKT_COUNT_EN is defined.
module cpu_nic #(
  parameter int DATA_W = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [0:1]        addr,
  input  logic [0:DATA_W-1] d_in,
  output logic [0:DATA_W-1] d_out,
  input  logic              nicEn,
  input  logic              nicEnWr,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity
);

  localparam logic [0:1] ADDR_IN_DATA   = 2'b00;
  localparam logic [0:1] ADDR_IN_STAT   = 2'b01;
  localparam logic [0:1] ADDR_OUT_DATA  = 2'b10;
  localparam logic [0:1] ADDR_OUT_STAT  = 2'b11;

  logic [0:DATA_W-1] inBuf;
  logic              inFull;
  logic [0:DATA_W-1] outBuf;
  logic              outFull;

  logic rdEn;
  logic wrEn;
  logic capture;
  logic drain;
  logic load;
  logic send;

  assign rdEn    = nicEn & ~nicEnWr;
  assign wrEn    = nicEn & nicEnWr;
  assign capture = net_si & ~inFull;
  // Draining an empty buffer is a no-op, so only a full buffer is cleared.
  assign drain   = rdEn & (addr == ADDR_IN_DATA) & inFull;
  assign load    = wrEn & (addr == ADDR_OUT_DATA) & ~outFull;
  assign send    = outFull & net_ro & ~net_polarity;

  assign net_ri = ~inFull;
  assign net_so = send;
  assign net_do = outBuf;

`ifdef NIC_PKT_COUNT_EN
  logic [15:0] rxCnt;
  logic [15:0] txCnt;

  function automatic logic [15:0] satInc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rxCnt <= '0;
      txCnt <= '0;
    end else begin
      if (capture) rxCnt <= satInc(rxCnt);
      if (send)    txCnt <= satInc(txCnt);
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      inBuf   <= '0;
      inFull  <= 1'b0;
      outBuf  <= '0;
      outFull <= 1'b0;
    end else begin
      if (capture) begin
        inBuf  <= net_di;
        inFull <= 1'b1;
      end else if (drain) begin
        inFull <= 1'b0;
      end
      if (load) begin
        outBuf  <= d_in;
        outFull <= 1'b1;
      end else if (send) begin
        outFull <= 1'b0;
      end
    end
  end

  // Status words carry the flag in the last bit and the packet count in the first 16 bits.
  logic [0:DATA_W-1] inStat;
  logic [0:DATA_W-1] outStat;

`ifdef NIC_PKT_COUNT_EN
  assign inStat  = {rxCnt, {(DATA_W-17){1'b0}}, inFull};
  assign outStat = {txCnt, {(DATA_W-17){1'b0}}, outFull};
`else
  assign inStat  = {{(DATA_W-1){1'b0}}, inFull};
  assign outStat = {{(DATA_W-1){1'b0}}, outFull};
`endif

  always_comb begin
    d_out = '0;
    if (rdEn) begin
      case (addr)
        ADDR_IN_DATA:  d_out = inBuf;
        ADDR_IN_STAT:  d_out = inStat;
        ADDR_OUT_DATA: d_out = '0;
        ADDR_OUT_STAT: d_out = outStat;
        default:       d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_nic.sv
// Directed bench for cpu_nic: expected values are queued at stimulus time and popped at each check.
module tb_cpu_nic;

`ifdef NIC_PKT_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic [0:1]  addr;
  logic [0:63] d_in;
  logic [0:63] d_out;
  logic        nicEn;
  logic        nicEnWr;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;

  int tests  = 0;
  int failed = 0;
  int rxCnt  = 0;
  int txCnt  = 0;
  logic [63:0] sb[$];

  cpu_nic dut (
    .CLK(CLK), .RESET(RESET), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicEnWr(nicEnWr), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] statusWord(input int cnt, input logic flag);
    logic [15:0] c;
    c = cnt[15:0];
    return CNT_EN ? {c, 47'b0, flag} : {63'b0, flag};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [1:0] a);
    nicEn = 1'b1; nicEnWr = 1'b0; addr = a;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] v);
    nicEn = 1'b1; nicEnWr = 1'b1; addr = a; d_in = v;
    #1;
  endtask

  task automatic idle();
    nicEn = 1'b0; nicEnWr = 1'b0; addr = 2'b00;
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs);
    logic [63:0] exp;
    tests++;
    if (sb.size() == 0) begin
      failed++;
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        failed++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  initial begin
    RESET = 1'b1; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicEnWr = 1'b0;
    net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
    tick(); tick();
    RESET = 1'b0;
    #1;

    // Reset state
    rd(2'b01); sb.push_back(64'h0); check("rst_in_stat", d_out);
    rd(2'b11); sb.push_back(64'h0); check("rst_out_stat", d_out);
    sb.push_back(64'h1); check("rst_net_ri", 64'(net_ri));
    sb.push_back(64'h0); check("rst_net_so", 64'(net_so));
    sb.push_back(64'h0); check("rst_net_do", net_do);
    idle(); sb.push_back(64'h0); check("idle_d_out", d_out);

    // Receive and drain
    net_si = 1'b1; net_di = 64'hDEADBEEF_00000001;
    sb.push_back(64'h0); check("rx_net_ri_pre", 64'(!net_ri));
    tick(); rxCnt++;
    net_si = 1'b0; #1;
    sb.push_back(64'h0); check("rx_net_ri_full", 64'(net_ri));
    rd(2'b01); sb.push_back(statusWord(rxCnt, 1'b1)); check("rx_in_stat", d_out);
    rd(2'b00); sb.push_back(64'hDEADBEEF_00000001); check("rx_in_data", d_out);
    tick(); idle();
    sb.push_back(64'h1); check("drain_net_ri", 64'(net_ri));
    rd(2'b00); sb.push_back(64'hDEADBEEF_00000001); check("stale_in_data", d_out);
    tick(); idle();
    sb.push_back(64'h1); check("stale_net_ri", 64'(net_ri));

    // Capture while full is ignored
    net_si = 1'b1; net_di = 64'hDEADBEEF_00000001;
    tick(); rxCnt++;
    net_di = 64'h5555; #1;
    tick();
    net_si = 1'b0;
    rd(2'b01); sb.push_back(statusWord(rxCnt, 1'b1)); check("full_in_stat", d_out);
    rd(2'b00); sb.push_back(64'hDEADBEEF_00000001); check("full_ignore", d_out);
    tick(); idle();

    // Output load, polarity gating, send
    net_ro = 1'b1; net_polarity = 1'b1;
    wr(2'b10, 64'hCAFE);
    sb.push_back(64'h0); check("wr_d_out_zero", d_out);
    tick(); idle();
    sb.push_back(64'h0); check("pol1_net_so", 64'(net_so));
    sb.push_back(64'hCAFE); check("load_net_do", net_do);
    rd(2'b11); sb.push_back(statusWord(txCnt, 1'b1)); check("load_out_stat", d_out);
    rd(2'b10); sb.push_back(64'h0); check("rd_out_data", d_out);
    idle();
    net_polarity = 1'b0; #1;
    sb.push_back(64'h1); check("pol0_net_so", 64'(net_so));
    sb.push_back(64'hCAFE); check("send_net_do", net_do);
    tick(); txCnt++;
    rd(2'b11); sb.push_back(statusWord(txCnt, 1'b0)); check("sent_out_stat", d_out);
    sb.push_back(64'h0); check("sent_net_so", 64'(net_so));
    idle();

    // Write while full is dropped; writes to other addresses ignored
    net_ro = 1'b0;
    wr(2'b10, 64'hCAFE); tick();
    wr(2'b10, 64'h1234); tick();
    wr(2'b00, 64'hFFFF_FFFF_FFFF_FFFF); tick();
    wr(2'b11, 64'h0); tick();
    wr(2'b01, 64'h1); tick();
    idle();
    sb.push_back(64'hCAFE); check("drop_net_do", net_do);
    rd(2'b11); sb.push_back(statusWord(txCnt, 1'b1)); check("drop_out_stat", d_out);
    rd(2'b01); sb.push_back(statusWord(rxCnt, 1'b0)); check("wr_in_stat_noeff", d_out);
    rd(2'b00); sb.push_back(64'hDEADBEEF_00000001); check("wr_in_data_noeff", d_out);
    idle();

    // Reset overrides a concurrent capture
    RESET = 1'b1; net_si = 1'b1; net_di = 64'h7777;
    tick();
    RESET = 1'b0; net_si = 1'b0; net_ro = 1'b1; net_polarity = 1'b0;
    rxCnt = 0; txCnt = 0; #1;
    sb.push_back(64'h0); check("post_rst_net_so", 64'(net_so));
    sb.push_back(64'h0); check("post_rst_net_do", net_do);
    sb.push_back(64'h1); check("post_rst_net_ri", 64'(net_ri));
    rd(2'b00); sb.push_back(64'h0); check("post_rst_in_data", d_out);
    rd(2'b01); sb.push_back(64'h0); check("post_rst_in_stat", d_out);
    rd(2'b11); sb.push_back(64'h0); check("post_rst_out_stat", d_out);
    idle();

    // Three receives, status read during capture sees pre-edge flag
    for (int i = 0; i < 3; i++) begin
      net_si = 1'b1; net_di = 64'h1000 + 64'(i);
      rd(2'b01); sb.push_back(statusWord(rxCnt, 1'b0)); check("cap_same_cycle_stat", d_out);
      tick(); rxCnt++;
      net_si = 1'b0;
      rd(2'b00); sb.push_back(64'h1000 + 64'(i)); check("rx_loop_data", d_out);
      tick(); idle();
    end

    // Two sends, each taking one cycle after the load
    for (int i = 0; i < 2; i++) begin
      wr(2'b10, 64'hA000 + 64'(i));
      tick(); idle();
      sb.push_back(64'h1); check("tx_loop_net_so", 64'(net_so));
      sb.push_back(64'hA000 + 64'(i)); check("tx_loop_net_do", net_do);
      tick(); txCnt++;
    end
    sb.push_back(64'h0); check("tx_done_net_so", 64'(net_so));
    rd(2'b01); sb.push_back(statusWord(rxCnt, 1'b0)); check("cnt_rx", d_out);
    rd(2'b11); sb.push_back(statusWord(txCnt, 1'b0)); check("cnt_tx", d_out);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
